// File: rtl/dsp_addsub_arbiter.sv
// Round-robin arbiter sharing one 32-bit DSP add/sub unit between two requesters.
// Operands are registered into the DSP; results return two cycles later, tagged by owner.
module dsp_addsub_arbiter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_sub,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_sub,
    output logic             rsp0_valid,
    output logic             rsp1_valid,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_zero,
    output logic [WIDTH-1:0] dsp_in1,
    output logic [WIDTH-1:0] dsp_in2,
    output logic             dsp_sub,
    input  logic [WIDTH-1:0] dsp_out,
    output logic             busy
);

    logic last;
    logic s1_valid;
    logic s1_id;
    logic s2_valid;
    logic s2_id;
    logic grant0;
    logic grant1;
    logic xfer;

    // A lone requester wins; on contention the one not granted last time wins.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!reset && !stall) begin
            grant0 = req0_valid && (!req1_valid || last);
            grant1 = req1_valid && (!req0_valid || !last);
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign xfer       = grant0 | grant1;

    // S1 captures the winner's operands; S2 captures the DSP result.
    always_ff @(posedge clk) begin
        if (reset) begin
            last     <= 1'b1;
            s1_valid <= 1'b0;
            s1_id    <= 1'b0;
            dsp_in1  <= '0;
            dsp_in2  <= '0;
            dsp_sub  <= 1'b0;
            s2_valid <= 1'b0;
            s2_id    <= 1'b0;
            rsp_data <= '0;
            rsp_zero <= 1'b0;
        end else if (!stall) begin
            if (xfer) begin
                dsp_in1 <= grant1 ? req1_a : req0_a;
                dsp_in2 <= grant1 ? req1_b : req0_b;
                dsp_sub <= grant1 ? req1_sub : req0_sub;
                s1_id   <= grant1;
                last    <= grant1;
            end
            s1_valid <= xfer;
            s2_valid <= s1_valid;
            s2_id    <= s1_id;
            rsp_data <= dsp_out;
            rsp_zero <= (dsp_out == '0);
        end
    end

    assign rsp0_valid = s2_valid && !s2_id;
    assign rsp1_valid = s2_valid && s2_id;
    assign busy       = s1_valid | s2_valid;

endmodule

// File: tb/tb_dsp_addsub_arbiter.sv
// Scoreboard bench for dsp_addsub_arbiter: directed stimulus pushes expected responses,
// a negedge monitor pops and compares them as the DUT presents results.
module tb_dsp_addsub_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        req0_valid, req0_ready, req0_sub;
    logic [31:0] req0_a, req0_b;
    logic        req1_valid, req1_ready, req1_sub;
    logic [31:0] req1_a, req1_b;
    logic        rsp0_valid, rsp1_valid, rsp_zero, dsp_sub, busy;
    logic [31:0] rsp_data, dsp_in1, dsp_in2, dsp_out;

    typedef struct packed {
        logic        v;
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] res;
    } req_t;

    typedef struct {
        logic        id;
        logic [31:0] data;
        logic        zero;
        int unsigned due;
    } exp_t;

    localparam req_t NONE = '0;

    exp_t        q[$];
    int          checks   = 0;
    int          failures = 0;
    int unsigned cyc      = 0;
    int unsigned act      = 0;
    logic        seen     = 1'b0;

    dsp_addsub_arbiter #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_data(rsp_data), .rsp_zero(rsp_zero),
        .dsp_in1(dsp_in1), .dsp_in2(dsp_in2), .dsp_sub(dsp_sub), .dsp_out(dsp_out), .busy(busy)
    );

    // Behavioural stand-in for the SB_MAC16 adder.
    assign dsp_out = dsp_sub ? dsp_in1 - dsp_in2 : dsp_in1 + dsp_in2;

    always #5 clk = ~clk;

    // act counts clock edges that actually advance the pipeline.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!stall && !reset) act <= act + 1;
    end

    function automatic req_t mk(input logic [31:0] a, input logic [31:0] b,
                                input logic sub, input logic [31:0] res);
        mk = '{1'b1, a, b, sub, res};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // One cycle of stimulus: drive, check readies mid-cycle, queue expected responses.
    task automatic step(input req_t r0, input req_t r1, input logic st,
                        input logic g0, input logic g1);
        exp_t e;
        req0_valid = r0.v; req0_a = r0.a; req0_b = r0.b; req0_sub = r0.sub;
        req1_valid = r1.v; req1_a = r1.a; req1_b = r1.b; req1_sub = r1.sub;
        stall = st;
        @(negedge clk);
        chk("req0_ready", 32'(req0_ready), 32'(g0));
        chk("req1_ready", 32'(req1_ready), 32'(g1));
        if (g0) begin
            e = '{1'b0, r0.res, (r0.res == 32'd0), act + 2};
            q.push_back(e);
        end
        if (g1) begin
            e = '{1'b1, r1.res, (r1.res == 32'd0), act + 2};
            q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(NONE, NONE, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: compare each presented response with the queue head; pop when not stalled.
    always @(negedge clk) begin
        if (cyc > 0 && !reset) begin
            if (q.size() == 0) begin
                chk("no_rsp", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
            end else if (rsp0_valid || rsp1_valid) begin
                chk("rsp_owner", {30'd0, rsp1_valid, rsp0_valid}, q[0].id ? 32'd2 : 32'd1);
                chk("rsp_data", rsp_data, q[0].data);
                chk("rsp_zero", 32'(rsp_zero), 32'(q[0].zero));
                if (!seen) chk("rsp_latency", act, q[0].due);
                if (stall) seen = 1'b1;
                else begin
                    seen = 1'b0;
                    void'(q.pop_front());
                end
            end else if (act > q[0].due) begin
                chk("rsp_missing", act, q[0].due);
                void'(q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        stall = 1'b0;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_sub = 1'b0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_sub = 1'b0;
        @(posedge clk);
        #1;
        // No grants while reset is high, even with both valid.
        step(mk(32'd1, 32'd1, 1'b0, 32'd2), mk(32'd1, 32'd1, 1'b0, 32'd2), 1'b0, 1'b0, 1'b0);
        step(mk(32'd1, 32'd1, 1'b0, 32'd2), mk(32'd1, 32'd1, 1'b0, 32'd2), 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_rsp_data", rsp_data, 32'd0);
        chk("reset_rsp_zero", 32'(rsp_zero), 32'd0);
        chk("reset_dsp_in1", dsp_in1, 32'd0);
        chk("reset_dsp_in2", dsp_in2, 32'd0);
        chk("reset_dsp_sub", 32'(dsp_sub), 32'd0);
        @(posedge clk);
        #1;

        // Single add
        step(mk(32'd5, 32'd3, 1'b0, 32'd8), NONE, 1'b0, 1'b1, 1'b0);
        idle(3);

        // Subtract with wrap, then subtract to zero
        step(NONE, mk(32'd0, 32'd1, 1'b1, 32'hFFFF_FFFF), 1'b0, 1'b0, 1'b1);
        step(NONE, mk(32'd7, 32'd7, 1'b1, 32'd0), 1'b0, 1'b0, 1'b1);
        idle(3);

        // Contention: last grant was requester 1, so requester 0 leads
        for (int i = 0; i < 2; i++) begin
            step(mk(32'd10, 32'd10, 1'b0, 32'd20), mk(32'd20, 32'd5, 1'b1, 32'd15), 1'b0, 1'b1, 1'b0);
            step(mk(32'd10, 32'd10, 1'b0, 32'd20), mk(32'd20, 32'd5, 1'b1, 32'd15), 1'b0, 1'b0, 1'b1);
        end
        idle(3);

        // Stall two cycles after a transfer; a waiting requester gets no ready meanwhile
        step(mk(32'd1, 32'd2, 1'b0, 32'd3), NONE, 1'b0, 1'b1, 1'b0);
        step(NONE, mk(32'd9, 32'd1, 1'b1, 32'd8), 1'b1, 1'b0, 1'b0);
        step(NONE, mk(32'd9, 32'd1, 1'b1, 32'd8), 1'b1, 1'b0, 1'b0);
        step(NONE, mk(32'd9, 32'd1, 1'b1, 32'd8), 1'b0, 1'b0, 1'b1);
        idle(4);

        // Stall while the response is on the outputs: held three cycles, then clear
        step(mk(32'd100, 32'd1, 1'b0, 32'd101), NONE, 1'b0, 1'b1, 1'b0);
        idle(1);
        step(NONE, NONE, 1'b1, 1'b0, 1'b0);
        step(NONE, NONE, 1'b1, 1'b0, 1'b0);
        idle(3);

        // Reset mid-flight (with stall also high): the pending response is dropped
        step(NONE, mk(32'd4, 32'd4, 1'b0, 32'd8), 1'b0, 1'b0, 1'b1);
        reset = 1'b1;
        q.delete();
        seen = 1'b0;
        step(mk(32'd1, 32'd1, 1'b0, 32'd2), mk(32'd1, 32'd1, 1'b0, 32'd2), 1'b1, 1'b0, 1'b0);
        reset = 1'b0;
        stall = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        chk("flush_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        step(mk(32'd6, 32'd2, 1'b1, 32'd4), mk(32'd6, 32'd2, 1'b0, 32'd8), 1'b0, 1'b1, 1'b0);
        step(NONE, mk(32'd6, 32'd2, 1'b0, 32'd8), 1'b0, 1'b0, 1'b1);
        idle(4);

        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dsp_addsub_arbiter.md
# dsp_addsub_arbiter

Shares the single SB_MAC16-based 32-bit add/subtract unit in sail-core between two requesters: requester 0 (ALU add/sub path) and requester 1 (branch compare / address path). It does three things:
- Arbitrates round-robin.
- Registers the winning operands into the DSP inputs.
- Registers the DSP result and routes it back to the owner with a fixed two-cycle latency.

A pipeline-wide stall freezes the whole block. The block lets one DSP serve both users instead of instantiating two MAC16 tiles.

## Interface
- WIDTH, 32: operand/result width. Fixed to the DSP's 32-bit datapath; other values are unsupported.
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  pipeline freeze; when high, no grants are issued and all registers hold.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 is granted this cycle (combinational).
- req0_a, req0_b  in  32 each  requester 0 operands.
- req0_sub  in  1  1 = a−b, 0 = a+b.
- req1_valid, req1_ready, req1_a, req1_b, req1_sub  same widths and meaning, for requester 1.
- rsp0_valid  out  1  result for requester 0 is on rsp_data this cycle.
- rsp1_valid  out  1  result for requester 1 is on rsp_data this cycle.
- rsp_data  out  32  registered result.
- rsp_zero  out  1  registered flag, rsp_data == 0.
- dsp_in1, dsp_in2  out  32 each  registered operands to the DSP adder.
- dsp_sub  out  1  registered add/sub select to the DSP (ADDSUBTOP/ADDSUBBOT).
- dsp_out  in  32  combinational DSP result, (dsp_in1 ± dsp_in2) mod 2^32.
- busy  out  1  s1_valid | s2_valid.

## Operation
- Handshake: a transfer on requester N happens when reqN_valid & reqN_ready in a cycle with stall = 0 and reset = 0.
  - The arbiter generates ready only when the matching valid is high.
  - The requester must hold valid and operands until ready. Dropping valid without a transfer is permitted.
- Arbitration, with 1-bit `last` = index of the most recent grant:
  - Only one valid: that requester is granted.
  - Both valid: the requester ≠ last is granted.
  - `last` updates only on a transfer.
  - Reset sets last = 1, so requester 0 wins the first contest.
- At most one ready is high per cycle. No ready is high while stall or reset is high.
- Stage S1 (on transfer):
  - dsp_in1 ← a, dsp_in2 ← b, dsp_sub ← sub, s1_id ← N, s1_valid ← 1.
  - With no transfer and no stall: s1_valid ← 0; the dsp_in*/dsp_sub values hold.
- Stage S2 (when not stalled):
  - rsp_data ← dsp_out, rsp_zero ← (dsp_out == 0), s2_id ← s1_id, s2_valid ← s1_valid.
- Outputs: rsp0_valid = s2_valid & (s2_id == 0); rsp1_valid = s2_valid & (s2_id == 1).
- Responses have no backpressure. The requester must sample rsp_data in the cycle its rspN_valid is high.
- Arithmetic is modulo 2^32. Carry and borrow are discarded; no overflow flag.
- Stall high:
  - All registers hold, including `last`, so rspN_valid stays high for the whole stall.
  - When stall falls, the block resumes exactly where it left off.
- Reset (synchronous, any cycle, including mid-operation):
  - s1_valid = s2_valid = 0, rsp_data = 0, rsp_zero = 0, dsp_in1 = dsp_in2 = 0, dsp_sub = 0, last = 1.
  - In-flight operations are dropped and produce no response.
  - reset outranks stall.
- Reset values of outputs: req*_ready = 0 (while reset high), rsp0/1_valid = 0, rsp_data = 0, rsp_zero = 0, dsp_* = 0, busy = 0.

## Timing
- Latency: transfer in cycle T → rspN_valid and rsp_data valid in cycle T+2, with no stall in T or T+1.
- Each stall cycle between T and T+2 adds one cycle.
- Throughput: one transfer per cycle sustained. Back-to-back transfers give back-to-back responses in grant order.
- Critical path: S1 registers → DSP combinational adder → S2 registers. This fits a single cycle at the sail-core clock.
- Contention: with both valid continuously, grants alternate 0,1,0,1… Neither requester waits more than one cycle.

## Test plan
- **Reset, then single add:**
  - Stimulus: req0 a=5, b=3, sub=0 in cycle 1.
  - Required: req0_ready=1 in cycle 1; rsp0_valid=1 with rsp_data=8, rsp_zero=0 in cycle 3; rsp1_valid=0 throughout.
- **Subtract with wrap and zero flag:**
  - req1 a=0, b=1, sub=1 → rsp_data=0xFFFFFFFF, rsp_zero=0.
  - Then a=7, b=7, sub=1 → rsp_data=0, rsp_zero=1.
- **Contention:**
  - Stimulus: both valid from cycle 1 for 4 cycles, req0 = (10+10), req1 = (20−5).
  - Required: grants 0,1,0,1; responses 20,15,20,15 on alternating rsp0_valid/rsp1_valid, cycles 3–6.
- **Stall:**
  - Stimulus: transfer req0 (1+2) in cycle 1, stall high in cycles 2–3.
  - Required: no ready in cycles 2–3; rsp0_valid=1 with rsp_data=3 in cycle 5.
- **Stall while the response is visible:**
  - Stimulus: stall high in the cycle rsp0_valid rises, held 2 cycles.
  - Required: rsp0_valid and rsp_data held for 3 cycles, then clear.
- **Reset mid-flight:**
  - Stimulus: transfer req1 (4+4) in cycle 1, reset in cycle 2.
  - Required: no rsp1_valid ever; busy=0 in cycle 3; next contest with both valid grants req0 first.
